// File: rtl/output_serializer.sv
// rtl/output_serializer.sv - width-reducing result-word to pad-beat serializer
//
// Accepts DATA_WIDTH-bit result words on a valid/ready handshake and emits
// them as BEATS = DATA_WIDTH/OUT_WIDTH consecutive OUT_WIDTH-bit beats on the
// pad-side valid/ready interface. A current-word shift register plus a
// one-word holding buffer sustain one beat per cycle across word boundaries.
//
// Build option: define OUTPUT_SER_MSB_FIRST_EN to send beats MSB first;
// the default build sends them LSB first.
//
// Ports:
//   clk          single clock
//   rst_n        asynchronous active-low reset
//   word_vld     upstream word valid
//   word_rdy     stage can accept a word (registered: ~nxt_vld)
//   word_data    upstream result word, DATA_WIDTH bits
//   output_vld   a beat is presented on the pads
//   output_rdy   pad-side consumer accepts the beat
//   output_data  current beat, OUT_WIDTH bits
//   busy         at least one word is held in the stage

module output_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  word_vld,
  output logic                  word_rdy,
  input  logic [DATA_WIDTH-1:0] word_data,
  output logic                  output_vld,
  input  logic                  output_rdy,
  output logic [OUT_WIDTH-1:0]  output_data,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [DATA_WIDTH-1:0] cur, cur_n;
  logic                  cur_vld, cur_vld_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DATA_WIDTH-1:0] nxt, nxt_n;
  logic                  nxt_vld, nxt_vld_n;

  logic                  word_fire;
  logic                  out_fire;
  logic                  last;
  logic [DATA_WIDTH-1:0] cur_shifted;

  // word_rdy comes only from registered state, so the upstream handshake
  // never waits on the pad-side ready.
  assign word_fire = word_vld & ~nxt_vld;
  assign out_fire  = cur_vld & output_rdy;
  assign last      = out_fire & (cnt == LAST_CNT);

`ifdef OUTPUT_SER_MSB_FIRST_EN
  assign cur_shifted = cur << OUT_WIDTH;
`else
  assign cur_shifted = cur >> OUT_WIDTH;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= '0;
      cur_vld <= 1'b0;
      cnt     <= '0;
      nxt     <= '0;
      nxt_vld <= 1'b0;
    end else begin
      cur     <= cur_n;
      cur_vld <= cur_vld_n;
      cnt     <= cnt_n;
      nxt     <= nxt_n;
      nxt_vld <= nxt_vld_n;
    end
  end

  // Next-state logic
  always_comb begin
    logic word_taken;
    cur_n      = cur;
    cur_vld_n  = cur_vld;
    cnt_n      = cnt;
    nxt_n      = nxt;
    nxt_vld_n  = nxt_vld;
    word_taken = 1'b0;

    if (last) begin
      cnt_n = '0;
      if (nxt_vld) begin
        cur_n     = nxt;
        nxt_vld_n = 1'b0;
      end else if (word_fire) begin
        // Incoming word replaces the finished one directly: no empty cycle.
        cur_n      = word_data;
        word_taken = 1'b1;
      end else begin
        cur_vld_n = 1'b0;
      end
    end else if (out_fire) begin
      cur_n = cur_shifted;
      cnt_n = cnt + CNT_W'(1);
    end

    if (word_fire && !word_taken) begin
      if (!cur_vld) begin
        cur_n     = word_data;
        cur_vld_n = 1'b1;
        cnt_n     = '0;
      end else begin
        nxt_n     = word_data;
        nxt_vld_n = 1'b1;
      end
    end
  end

  // Outputs, all decoded from registers
  assign word_rdy   = ~nxt_vld;
  assign output_vld = cur_vld;
  assign busy       = cur_vld | nxt_vld;

`ifdef OUTPUT_SER_MSB_FIRST_EN
  assign output_data = cur[DATA_WIDTH-1 -: OUT_WIDTH];
`else
  assign output_data = cur[OUT_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_output_serializer.sv
// tb/tb_output_serializer.sv - self-checking bench for output_serializer
module tb_output_serializer;

  localparam int DW    = 32;
  localparam int OW    = 8;
  localparam int BEATS = DW / OW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          word_vld = 1'b0;
  logic          word_rdy;
  logic [DW-1:0] word_data = '0;
  logic          output_vld;
  logic          output_rdy = 1'b0;
  logic [OW-1:0] output_data;
  logic          busy;

  int tests = 0;
  int fails = 0;

  output_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_vld   (word_vld),
    .word_rdy   (word_rdy),
    .word_data  (word_data),
    .output_vld (output_vld),
    .output_rdy (output_rdy),
    .output_data(output_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // i-th beat of a word in transmission order
  function automatic logic [OW-1:0] beat_of(input logic [DW-1:0] w, input int i);
`ifdef OUTPUT_SER_MSB_FIRST_EN
    return w[(BEATS-1-i)*OW +: OW];
`else
    return w[i*OW +: OW];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; word_vld = 1'b1; word_data = 32'hDEADBEEF; output_rdy = 1'b1;
    step(); step();
    tests++; if (output_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b expected 0", output_vld); end
    tests++; if (output_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", output_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (word_rdy !== 1'b1) begin fails++; $display("FAIL reset_word_rdy: got %b expected 1", word_rdy); end
    word_vld = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    logic [DW-1:0] w;
    w = 32'hA1B2C3D4;
    word_data = w; word_vld = 1'b1; output_rdy = 1'b1;
    tests++; if (word_rdy !== 1'b1) begin fails++; $display("FAIL single_word_rdy: got %b expected 1", word_rdy); end
    step();
    word_vld = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      tests++;
      if (output_vld !== 1'b1 || output_data !== beat_of(w, i)) begin
        fails++; $display("FAIL single_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, output_vld, output_data, beat_of(w, i));
      end
      step();
    end
    tests++; if (busy !== 1'b0 || output_vld !== 1'b0) begin fails++; $display("FAIL single_idle: got busy=%b vld=%b expected 0 0", busy, output_vld); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w [2];
    w[0] = 32'h03020100; w[1] = 32'h07060504;
    output_rdy = 1'b1; word_data = w[0]; word_vld = 1'b1;
    step();
    word_data = w[1];
    for (int i = 0; i < 2*BEATS; i++) begin
      tests++;
      if (output_vld !== 1'b1 || output_data !== beat_of(w[i/BEATS], i%BEATS)) begin
        fails++; $display("FAIL b2b_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, output_vld, output_data, beat_of(w[i/BEATS], i%BEATS));
      end
      if (i == 0) begin
        tests++; if (word_rdy !== 1'b1) begin fails++; $display("FAIL b2b_word_rdy: got %b expected 1", word_rdy); end
      end
      step();
      if (i == 0) word_vld = 1'b0;
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] ws [3];
    logic [OW-1:0] q [$];
    logic          wf;
    int            acc;
    int            seen;
    bit            done_w2;
    ws[0] = 32'h03020100; ws[1] = 32'h07060504; ws[2] = 32'h0B0A0908;
    acc = 0;
    output_rdy = 1'b0; word_vld = 1'b1; word_data = ws[0];
    for (int c = 0; c < 10; c++) begin
      if (acc >= 2) begin
        tests++; if (word_rdy !== 1'b0) begin fails++; $display("FAIL stall_word_rdy c%0d: got %b expected 0", c, word_rdy); end
      end
      if (acc >= 1) begin
        tests++;
        if (output_vld !== 1'b1 || output_data !== beat_of(ws[0], 0)) begin
          fails++; $display("FAIL stall_hold c%0d: got vld=%b data=%h expected vld=1 data=%h", c, output_vld, output_data, beat_of(ws[0], 0));
        end
      end
      wf = word_vld & word_rdy;
      step();
      if (wf) begin acc++; word_data = ws[acc]; end
    end
    tests++; if (acc != 2) begin fails++; $display("FAIL stall_accepts: got %0d expected 2", acc); end

    for (int k = 0; k < BEATS; k++) q.push_back(beat_of(ws[0], k));
    for (int k = 0; k < BEATS; k++) q.push_back(beat_of(ws[1], k));
    output_rdy = 1'b1;
    seen = 0; done_w2 = 1'b0;
    for (int c = 0; c < 40 && (q.size() > 0 || !done_w2); c++) begin
      if (seen == BEATS-1) begin
        tests++; if (word_rdy !== 1'b0) begin fails++; $display("FAIL stall_rdy_before_last: got %b expected 0", word_rdy); end
      end
      if (seen == BEATS) begin
        tests++; if (word_rdy !== 1'b1) begin fails++; $display("FAIL stall_rdy_after_last: got %b expected 1", word_rdy); end
      end
      wf = word_vld & word_rdy;
      if (wf) for (int k = 0; k < BEATS; k++) q.push_back(beat_of(ws[2], k));
      if (q.size() > 0) begin
        tests++;
        if (output_vld !== 1'b1 || output_data !== q[0]) begin
          fails++; $display("FAIL stall_drain_beat%0d: got vld=%b data=%h expected vld=1 data=%h", seen, output_vld, output_data, q[0]);
        end
        if (output_vld === 1'b1) begin void'(q.pop_front()); seen++; end
      end
      step();
      if (wf) begin word_vld = 1'b0; done_w2 = 1'b1; end
    end
    tests++;
    if (q.size() != 0 || !done_w2 || busy !== 1'b0) begin
      fails++; $display("FAIL stall_complete: got left=%0d w2=%b busy=%b expected 0 1 0", q.size(), done_w2, busy);
    end
    word_vld = 1'b0;
  endtask

  task automatic test_random();
    logic [OW-1:0] q [$];
    logic [DW-1:0] w;
    logic          prev_stall;
    logic [OW-1:0] prev_data;
    int            sent;
    sent = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 5000 && (sent < 100 || q.size() > 0); cyc++) begin
      w = $urandom;
      word_vld   = (sent < 100) && ($urandom_range(0, 3) != 0);
      word_data  = w;
      output_rdy = $urandom_range(0, 1) == 1;
      if (prev_stall) begin
        tests++;
        if (output_vld !== 1'b1 || output_data !== prev_data) begin
          fails++; $display("FAIL rand_hold cyc%0d: got vld=%b data=%h expected vld=1 data=%h", cyc, output_vld, output_data, prev_data);
        end
      end
      if (word_vld && word_rdy) begin
        for (int k = 0; k < BEATS; k++) q.push_back(beat_of(w, k));
        sent++;
      end
      if (output_vld && output_rdy) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rand_extra_beat cyc%0d: got data=%h expected no beat", cyc, output_data);
        end else begin
          if (output_data !== q[0]) begin
            fails++; $display("FAIL rand_beat cyc%0d: got %h expected %h", cyc, output_data, q[0]);
          end
          void'(q.pop_front());
        end
      end
      prev_stall = output_vld & ~output_rdy;
      prev_data  = output_data;
      step();
    end
    word_vld = 1'b0; output_rdy = 1'b0;
    tests++;
    if (sent != 100 || q.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL rand_complete: got sent=%0d left=%0d busy=%b expected 100 0 0", sent, q.size(), busy);
    end
  endtask

  task automatic test_reset_midword();
    logic [DW-1:0] w;
    output_rdy = 1'b1; word_data = 32'h11223344; word_vld = 1'b1;
    step();
    word_vld = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (output_vld !== 1'b0 || output_data !== 8'h00 || busy !== 1'b0 || word_rdy !== 1'b1) begin
      fails++; $display("FAIL midreset_async: got vld=%b data=%h busy=%b rdy=%b expected 0 00 0 1", output_vld, output_data, busy, word_rdy);
    end
    word_vld = 1'b1; word_data = 32'hFFFFFFFF;
    step();
    tests++;
    if (output_vld !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midreset_ignore_hs: got vld=%b busy=%b expected 0 0", output_vld, busy);
    end
    word_vld = 1'b0;
    rst_n = 1'b1;
    step();
    w = 32'h55667788;
    word_data = w; word_vld = 1'b1;
    step();
    word_vld = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      tests++;
      if (output_vld !== 1'b1 || output_data !== beat_of(w, i)) begin
        fails++; $display("FAIL midreset_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, output_vld, output_data, beat_of(w, i));
      end
      step();
    end
    tests++; if (busy !== 1'b0 || output_vld !== 1'b0) begin fails++; $display("FAIL midreset_idle: got busy=%b vld=%b expected 0 0", busy, output_vld); end
  endtask

  task automatic test_last_coincident();
    logic [DW-1:0] w0, w1;
    w0 = 32'hCAFE1234; w1 = 32'h9876ABCD;
    output_rdy = 1'b1; word_data = w0; word_vld = 1'b1;
    step();
    word_vld = 1'b0;
    for (int i = 0; i < BEATS; i++) begin
      tests++;
      if (output_vld !== 1'b1 || output_data !== beat_of(w0, i)) begin
        fails++; $display("FAIL coinc_w0_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, output_vld, output_data, beat_of(w0, i));
      end
      if (i == BEATS-1) begin
        word_data = w1; word_vld = 1'b1;
        tests++; if (word_rdy !== 1'b1) begin fails++; $display("FAIL coinc_word_rdy: got %b expected 1", word_rdy); end
      end
      step();
      if (i == BEATS-1) word_vld = 1'b0;
    end
    for (int i = 0; i < BEATS; i++) begin
      tests++;
      if (output_vld !== 1'b1 || output_data !== beat_of(w1, i)) begin
        fails++; $display("FAIL coinc_w1_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, output_vld, output_data, beat_of(w1, i));
      end
      step();
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL coinc_idle: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midword();
    test_last_coincident();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
